// File: rtl/led_switch_io.sv
// led_switch_io: memory-mapped LED output register plus synchronized switch input.
// Optional feature: define SW_DEBOUNCE_EN to require DB_CNT stable cycles before a
// switch change is accepted; with it undefined the synchronized value is accepted
// every edge and DB_CNT is unused.
module led_switch_io #(
  parameter int unsigned DB_CNT = 1000000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        led_cs,
  input  logic        sw_cs,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [23:0] switch_in,
  output logic [23:0] led_out,
  output logic [31:0] io_rdata
);

  localparam logic [31:0] LED_DATA = 32'hFFFF_FC60;
  localparam logic [31:0] SW_DATA  = 32'hFFFF_FC70;
  localparam logic [31:0] SW_STAT  = 32'hFFFF_FC74;

  logic [23:0] led_q, led_d;
  logic [23:0] s1_q, s2_q, s3_q;
  logic [23:0] sw_db_q, sw_db_d;
  logic        changed_q, changed_d;
  logic        led_wr, data_rd, stat_rd;

  assign led_wr  = led_cs && (addr == LED_DATA);
  assign data_rd = sw_cs  && (addr == SW_DATA);
  assign stat_rd = sw_cs  && (addr == SW_STAT);
  assign led_out = led_q;

  // LED register loads the low 24 data bits on a write to LED_DATA
  always_comb begin
    led_d = led_q;
    if (led_wr) led_d = wdata[23:0];
  end

`ifdef SW_DEBOUNCE_EN
  localparam logic [19:0] CNT_LAST = 20'(DB_CNT - 1);

  logic [19:0] cnt_q, cnt_d;

  // Accept s2 once it has been stable and different from sw_db for DB_CNT edges
  always_comb begin
    sw_db_d = sw_db_q;
    cnt_d   = cnt_q + 20'd1;
    if ((s2_q != s3_q) || (s2_q == sw_db_q)) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      sw_db_d = s2_q;
      cnt_d   = '0;
    end
  end

  // Debounce counter register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
`else
  // History flop and DB_CNT have no consumer in this build
  logic [23:0] unused_s3;
  logic [31:0] unused_db_cnt;
  assign unused_s3     = s3_q;
  assign unused_db_cnt = 32'(DB_CNT);

  // Without debounce the synchronized value is accepted on every edge
  always_comb begin
    sw_db_d = s2_q;
  end
`endif

  // Sticky change flag: cleared by an SW_STAT read, but a new acceptance wins
  always_comb begin
    changed_d = changed_q;
    if (stat_rd)            changed_d = 1'b0;
    if (sw_db_d != sw_db_q) changed_d = 1'b1;
  end

  // Combinational read mux so a single-cycle load completes in the same cycle
  always_comb begin
    io_rdata = '0;
    if (data_rd)      io_rdata = {8'b0, sw_db_q};
    else if (stat_rd) io_rdata = {31'b0, changed_q};
  end

  // All architectural state
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      led_q     <= '0;
      s1_q      <= '0;
      s2_q      <= '0;
      s3_q      <= '0;
      sw_db_q   <= '0;
      changed_q <= 1'b0;
    end else begin
      led_q     <= led_d;
      s1_q      <= switch_in;
      s2_q      <= s1_q;
      s3_q      <= s2_q;
      sw_db_q   <= sw_db_d;
      changed_q <= changed_d;
    end
  end

endmodule

// File: tb/tb_led_switch_io.sv
// Testbench for led_switch_io; expectations are queued when stimulus is driven
// and popped when the corresponding output is sampled.
module tb_led_switch_io;

  localparam int unsigned DB = 4;
`ifdef SW_DEBOUNCE_EN
  localparam int unsigned LAT = DB + 3;
  localparam logic [31:0] GLITCH_STAT = 32'h0;
`else
  localparam int unsigned LAT = 3;
  localparam logic [31:0] GLITCH_STAT = 32'h1;
`endif

  localparam logic [31:0] LED_DATA = 32'hFFFF_FC60;
  localparam logic [31:0] SW_DATA  = 32'hFFFF_FC70;
  localparam logic [31:0] SW_STAT  = 32'hFFFF_FC74;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        led_cs = 1'b0;
  logic        sw_cs = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [23:0] switch_in = '0;
  logic [23:0] led_out;
  logic [31:0] io_rdata;

  logic [31:0] exp_q[$];
  logic [31:0] exp_v, got;
  int n_checks = 0;
  int n_fail = 0;

  always #5 clock = ~clock;

  led_switch_io #(.DB_CNT(DB)) dut (
    .clock     (clock),
    .reset     (reset),
    .led_cs    (led_cs),
    .sw_cs     (sw_cs),
    .addr      (addr),
    .wdata     (wdata),
    .switch_in (switch_in),
    .led_out   (led_out),
    .io_rdata  (io_rdata)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) tick();
    exp_q.push_back(32'h0);
    got = {8'b0, led_out}; exp_v = exp_q.pop_front(); n_checks++;
    if (got !== exp_v) begin n_fail++; $display("FAIL reset_led: got %h expected %h", got, exp_v); end
    sw_cs = 1'b1; addr = SW_DATA; #1;
    exp_q.push_back(32'h0);
    got = io_rdata; exp_v = exp_q.pop_front(); n_checks++;
    if (got !== exp_v) begin n_fail++; $display("FAIL reset_swdata: got %h expected %h", got, exp_v); end
    addr = SW_STAT; #1;
    exp_q.push_back(32'h0);
    got = io_rdata; exp_v = exp_q.pop_front(); n_checks++;
    if (got !== exp_v) begin n_fail++; $display("FAIL reset_swstat: got %h expected %h", got, exp_v); end
    sw_cs = 1'b0; addr = '0;
    reset = 1'b0;
    tick();
  endtask

  task automatic test_led_write();
    led_cs = 1'b1; addr = LED_DATA; wdata = 32'h12AB_CDEF; #1;
    exp_q.push_back(32'h0);
    got = {8'b0, led_out}; exp_v = exp_q.pop_front(); n_checks++;
    if (got !== exp_v) begin n_fail++; $display("FAIL led_before_edge: got %h expected %h", got, exp_v); end
    exp_q.push_back(32'h00AB_CDEF);
    tick(); led_cs = 1'b0;
    got = {8'b0, led_out}; exp_v = exp_q.pop_front(); n_checks++;
    if (got !== exp_v) begin n_fail++; $display("FAIL led_write: got %h expected %h", got, exp_v); end
    led_cs = 1'b1; addr = 32'hFFFF_FC64; wdata = 32'h00FF_FFFF;
    exp_q.push_back(32'h00AB_CDEF);
    tick(); led_cs = 1'b0;
    got = {8'b0, led_out}; exp_v = exp_q.pop_front(); n_checks++;
    if (got !== exp_v) begin n_fail++; $display("FAIL led_wrong_addr: got %h expected %h", got, exp_v); end
    addr = LED_DATA; wdata = 32'h0055_5555;
    exp_q.push_back(32'h00AB_CDEF);
    tick();
    got = {8'b0, led_out}; exp_v = exp_q.pop_front(); n_checks++;
    if (got !== exp_v) begin n_fail++; $display("FAIL led_no_cs: got %h expected %h", got, exp_v); end
    addr = '0;
  endtask

  task automatic test_debounce_latency();
    switch_in = 24'h00000F; sw_cs = 1'b1; addr = SW_DATA;
    for (int k = 1; k <= int'(LAT) + 1; k++) begin
      exp_q.push_back((k >= int'(LAT)) ? 32'h0000_000F : 32'h0);
      tick();
      got = io_rdata; exp_v = exp_q.pop_front(); n_checks++;
      if (got !== exp_v) begin n_fail++; $display("FAIL latency_edge%0d: got %h expected %h", k, got, exp_v); end
    end
    sw_cs = 1'b0;
  endtask

  task automatic test_sticky();
    sw_cs = 1'b1; addr = SW_STAT; #1;
    exp_q.push_back(32'h1);
    got = io_rdata; exp_v = exp_q.pop_front(); n_checks++;
    if (got !== exp_v) begin n_fail++; $display("FAIL sticky_set: got %h expected %h", got, exp_v); end
    exp_q.push_back(32'h0);
    tick();
    got = io_rdata; exp_v = exp_q.pop_front(); n_checks++;
    if (got !== exp_v) begin n_fail++; $display("FAIL sticky_clear: got %h expected %h", got, exp_v); end
    sw_cs = 1'b0;
  endtask

  task automatic test_set_wins();
    switch_in = 24'h000000;
    repeat (LAT - 1) tick();
    sw_cs = 1'b1; addr = SW_STAT; #1;
    exp_q.push_back(32'h0);
    got = io_rdata; exp_v = exp_q.pop_front(); n_checks++;
    if (got !== exp_v) begin n_fail++; $display("FAIL pre_accept_stat: got %h expected %h", got, exp_v); end
    exp_q.push_back(32'h1);
    tick();
    got = io_rdata; exp_v = exp_q.pop_front(); n_checks++;
    if (got !== exp_v) begin n_fail++; $display("FAIL set_wins: got %h expected %h", got, exp_v); end
    exp_q.push_back(32'h0);
    tick();
    got = io_rdata; exp_v = exp_q.pop_front(); n_checks++;
    if (got !== exp_v) begin n_fail++; $display("FAIL clear_after_set: got %h expected %h", got, exp_v); end
    addr = SW_DATA; #1;
    exp_q.push_back(32'h0);
    got = io_rdata; exp_v = exp_q.pop_front(); n_checks++;
    if (got !== exp_v) begin n_fail++; $display("FAIL swdata_after_release: got %h expected %h", got, exp_v); end
    sw_cs = 1'b0;
  endtask

  task automatic test_glitch();
    switch_in = 24'h000001;
    repeat (3) tick();
    switch_in = 24'h000000;
    repeat (LAT + 3) tick();
    sw_cs = 1'b1; addr = SW_DATA; #1;
    exp_q.push_back(32'h0);
    got = io_rdata; exp_v = exp_q.pop_front(); n_checks++;
    if (got !== exp_v) begin n_fail++; $display("FAIL glitch_data: got %h expected %h", got, exp_v); end
    addr = SW_STAT; #1;
    exp_q.push_back(GLITCH_STAT);
    got = io_rdata; exp_v = exp_q.pop_front(); n_checks++;
    if (got !== exp_v) begin n_fail++; $display("FAIL glitch_stat: got %h expected %h", got, exp_v); end
    tick();
    sw_cs = 1'b0;
  endtask

  task automatic test_simultaneous();
    switch_in = 24'h00003C;
    repeat (LAT + 1) tick();
    led_cs = 1'b1; sw_cs = 1'b1; addr = SW_STAT; wdata = 32'h0077_7777; #1;
    exp_q.push_back(32'h1);
    got = io_rdata; exp_v = exp_q.pop_front(); n_checks++;
    if (got !== exp_v) begin n_fail++; $display("FAIL both_cs_stat: got %h expected %h", got, exp_v); end
    exp_q.push_back(32'h00AB_CDEF);
    exp_q.push_back(32'h0);
    tick();
    got = {8'b0, led_out}; exp_v = exp_q.pop_front(); n_checks++;
    if (got !== exp_v) begin n_fail++; $display("FAIL both_cs_led_kept: got %h expected %h", got, exp_v); end
    got = io_rdata; exp_v = exp_q.pop_front(); n_checks++;
    if (got !== exp_v) begin n_fail++; $display("FAIL both_cs_cleared: got %h expected %h", got, exp_v); end
    addr = LED_DATA; #1;
    exp_q.push_back(32'h0);
    got = io_rdata; exp_v = exp_q.pop_front(); n_checks++;
    if (got !== exp_v) begin n_fail++; $display("FAIL both_cs_rd_led_addr: got %h expected %h", got, exp_v); end
    exp_q.push_back(32'h0077_7777);
    tick();
    got = {8'b0, led_out}; exp_v = exp_q.pop_front(); n_checks++;
    if (got !== exp_v) begin n_fail++; $display("FAIL both_cs_led_write: got %h expected %h", got, exp_v); end
    led_cs = 1'b0; sw_cs = 1'b0; addr = '0;
  endtask

  task automatic test_reset_mid_hold();
    switch_in = 24'h800000;
    repeat (2) tick();
    #2 reset = 1'b1; sw_cs = 1'b1; addr = SW_DATA; #1;
    exp_q.push_back(32'h0);
    got = {8'b0, led_out}; exp_v = exp_q.pop_front(); n_checks++;
    if (got !== exp_v) begin n_fail++; $display("FAIL async_reset_led: got %h expected %h", got, exp_v); end
    exp_q.push_back(32'h0);
    got = io_rdata; exp_v = exp_q.pop_front(); n_checks++;
    if (got !== exp_v) begin n_fail++; $display("FAIL async_reset_swdata: got %h expected %h", got, exp_v); end
    tick();
    reset = 1'b0;
    for (int k = 1; k <= int'(LAT); k++) begin
      exp_q.push_back((k >= int'(LAT)) ? 32'h0080_0000 : 32'h0);
      tick();
      got = io_rdata; exp_v = exp_q.pop_front(); n_checks++;
      if (got !== exp_v) begin n_fail++; $display("FAIL post_reset_edge%0d: got %h expected %h", k, got, exp_v); end
    end
    addr = SW_STAT; #1;
    exp_q.push_back(32'h1);
    got = io_rdata; exp_v = exp_q.pop_front(); n_checks++;
    if (got !== exp_v) begin n_fail++; $display("FAIL post_reset_stat: got %h expected %h", got, exp_v); end
    sw_cs = 1'b0; addr = '0;
  endtask

  initial begin
    test_reset();
    test_led_write();
    test_debounce_latency();
    test_sticky();
    test_set_wins();
    test_glitch();
    test_simultaneous();
    test_reset_mid_hold();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/led_switch_io.md
LED_SWITCH_IO -- requirements
Module: led_switch_io

Interface
REQ-001 Parameter: DB_CNT, default 1000000, number of consecutive stable clock cycles required before a switch change is accepted (1 to 2^20-1).
REQ-002 clock  input  1  system clock, all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 led_cs  input  1  LED chip select (ioWrite from the memory/IO mux), active high.
REQ-005 sw_cs  input  1  switch chip select (ioRead from the memory/IO mux), active high.
REQ-006 addr  input  32  byte address (ALU result passed through the memory/IO mux).
REQ-007 wdata  input  32  write data from the memory/IO mux.
REQ-008 switch_in  input  24  raw, asynchronous board switch levels.
REQ-009 led_out  output  24  registered LED drive.
REQ-010 io_rdata  output  32  read data returned to the memory/IO mux.

Function
REQ-011 The block SHALL decode three addresses: LED_DATA 0xFFFFFC60, SW_DATA 0xFFFFFC70 and SW_STAT 0xFFFFFC74.
REQ-012 With led_cs=1 and addr=LED_DATA, led_out SHALL load wdata[23:0] on the same rising edge.
REQ-013 LED writes to any other address SHALL be ignored.
REQ-014 io_rdata SHALL be combinational, so that a single-cycle load completes in the same cycle:
- sw_cs=1 and addr=SW_DATA: {8'b0, sw_db}.
- sw_cs=1 and addr=SW_STAT: {31'b0, changed}.
- all other cases: 0.
REQ-015 switch_in SHALL pass through two synchronizer flops s1 and s2, plus a history flop s3 that holds the previous value of s2.
REQ-016 A 20-bit counter cnt SHALL update on every edge:
- cnt <= 0 when s2 != s3 or s2 == sw_db.
- otherwise, when cnt == DB_CNT-1: sw_db <= s2 and cnt <= 0.
- otherwise: cnt <= cnt+1.
REQ-017 Latency: if switch_in changes and then holds, the first edge samples the new value into s1, and sw_db SHALL take the new value on edge DB_CNT+3 counted from that first edge.
REQ-018 A glitch shorter than DB_CNT cycles SHALL NOT alter sw_db.
REQ-019 The sticky flag changed SHALL be set on any edge where sw_db takes a value different from its previous value.
REQ-020 changed SHALL be cleared on the edge at which sw_cs=1 and addr=SW_STAT.
REQ-021 When a set condition and a clear condition occur on the same edge, set SHALL win and changed SHALL remain 1.
REQ-022 Simultaneous led_cs and sw_cs SHALL both take effect independently.

Reset
REQ-023 On reset assertion, the following SHALL clear to 0 immediately, independent of clock: led_out, s1, s2, s3, sw_db, cnt and changed.
REQ-024 If reset asserts mid-debounce, the pending change SHALL be discarded, and counting SHALL restart from 0 after reset release.

Configuration
REQ-025 Macro SW_DEBOUNCE_EN defined: debounce SHALL operate per REQ-016 to REQ-018.
REQ-026 Macro SW_DEBOUNCE_EN undefined:
- cnt SHALL be absent and DB_CNT SHALL be unused.
- sw_db <= s2 on every edge, so a change reaches sw_db on edge 3.
- changed SHALL still follow REQ-019 to REQ-021.

Verification
REQ-027 Reset, then write LED: reset pulse, then led_cs=1, addr=0xFFFFFC60, wdata=0x12ABCDEF -> led_out=0xABCDEF after the edge.
REQ-028 Write to the wrong address: led_cs=1, addr=0xFFFFFC64, wdata=0xFFFFFF -> led_out is unchanged.
REQ-029 Debounce latency: DB_CNT=4, macro defined, switch_in 0 -> 0x00000F held -> SW_DATA read returns 0 through edge 6 and 0x0000000F from edge 7.
REQ-030 Glitch rejection: DB_CNT=4, switch_in=0x000001 for 3 cycles, then 0 -> sw_db stays 0 and changed stays 0.
REQ-031 Sticky flag and set-wins:
- After an accepted change, an SW_STAT read returns 1 and changed is 0 on the next edge.
- A read coinciding with a new acceptance leaves changed at 1.
REQ-032 Macro undefined: switch_in 0 -> 0x800000 -> sw_db=0x800000 on edge 3; reset mid-hold -> all outputs 0 immediately.
